// File: rtl/hbm_csr_pkg.sv
// Shared register map, bit positions and response codes for the FC+BN+RES layer CSR block.
// Pure constants and types; no logic.
// No flow control.
package hbm_csr_pkg;

    localparam logic [7:0] REG_CTRL          = 8'h00;
    localparam logic [7:0] REG_STATUS        = 8'h04;
    localparam logic [7:0] REG_CH_IN         = 8'h08;
    localparam logic [7:0] REG_HIN           = 8'h0C;
    localparam logic [7:0] REG_WIN           = 8'h10;
    localparam logic [7:0] REG_CH_OUT        = 8'h14;
    localparam logic [7:0] REG_DAT_IN_BASE   = 8'h18;
    localparam logic [7:0] REG_DAT_IN_SURF   = 8'h1C;
    localparam logic [7:0] REG_DAT_IN_LINE   = 8'h20;
    localparam logic [7:0] REG_WT_BASE       = 8'h24;
    localparam logic [7:0] REG_WT_SIZE_BYTES = 8'h28;
    localparam logic [7:0] REG_WT_NUM_DIV    = 8'h2C;
    localparam logic [7:0] REG_BN_BASE       = 8'h30;
    localparam logic [7:0] REG_RES_BASE      = 8'h34;
    localparam logic [7:0] REG_RES_SURF      = 8'h38;
    localparam logic [7:0] REG_RES_LINE      = 8'h3C;
    localparam logic [7:0] REG_OUT_BASE      = 8'h40;
    localparam logic [7:0] REG_OUT_SURF      = 8'h44;
    localparam logic [7:0] REG_OUT_LINE      = 8'h48;

    localparam int CTRL_START   = 0;
    localparam int CTRL_RELU_EN = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } eng_state_t;

endpackage

// File: rtl/hbm_fc_bn_res_csr_wr_join.sv
// AXI-Lite AW/W one-entry holding registers joined into a single write request.
// Latency: wr_req the cycle after both are held; bvalid registered with the commit.
// Backpressure: awready/wready drop while held; both freed only on the B handshake.
module axil_wr_join
    import hbm_csr_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic                  wr_req,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W/8-1:0]   wr_strb,
    input  logic                  wr_ack,
    input  logic [1:0]            wr_resp
);

    logic aw_held, w_held;
    logic aw_held_nxt, w_held_nxt;
    logic aw_hs, w_hs, b_hs;

    assign aw_hs  = s_awvalid && s_awready;
    assign w_hs   = s_wvalid && s_wready;
    assign b_hs   = s_bvalid && s_bready;
    // bvalid masks the request so a held pair commits exactly once.
    assign wr_req = aw_held && w_held && !s_bvalid;

    always_comb begin
        aw_held_nxt = aw_held;
        w_held_nxt  = w_held;
        if (aw_hs) aw_held_nxt = 1'b1;
        if (w_hs)  w_held_nxt  = 1'b1;
        if (b_hs) begin
            aw_held_nxt = 1'b0;
            w_held_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_strb   <= '0;
        end else begin
            aw_held   <= aw_held_nxt;
            w_held    <= w_held_nxt;
            s_awready <= !aw_held_nxt;
            s_wready  <= !w_held_nxt;
            if (aw_hs) wr_addr <= s_awaddr;
            if (w_hs) begin
                wr_data <= s_wdata;
                wr_strb <= s_wstrb;
            end
            if (wr_req && wr_ack) begin
                s_bvalid <= 1'b1;
                s_bresp  <= wr_resp;
            end else if (b_hs) begin
                s_bvalid <= 1'b0;
                s_bresp  <= RESP_OKAY;
            end
        end
    end

endmodule

// File: rtl/hbm_fc_bn_res_csr.sv
// AXI-Lite register slave configuring one FC+BN+RES layer, with start/busy/done and level irq.
// Latency: write response 1 cycle after the later AW/W handshake; read data 1 cycle after AR.
// Backpressure: one write and one read outstanding; readies drop until B/R handshakes.
module hbm_fc_bn_res_csr
    import hbm_csr_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 19
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            s_awaddr,
    input  logic                         s_awvalid,
    output logic                         s_awready,
    input  logic [DATA_W-1:0]            s_wdata,
    input  logic [DATA_W/8-1:0]          s_wstrb,
    input  logic                         s_wvalid,
    output logic                         s_wready,
    output logic [1:0]                   s_bresp,
    output logic                         s_bvalid,
    input  logic                         s_bready,
    input  logic [ADDR_W-1:0]            s_araddr,
    input  logic                         s_arvalid,
    output logic                         s_arready,
    output logic [DATA_W-1:0]            s_rdata,
    output logic [1:0]                   s_rresp,
    output logic                         s_rvalid,
    input  logic                         s_rready,
    output logic [(NUM_REGS-1)*DATA_W-1:0] cfg_flat,
    output logic                         cfg_relu_en,
    output logic                         eng_start,
    input  logic                         eng_done,
    output logic                         irq
);

    localparam int IW     = ADDR_W - 2;
    localparam int NCFG   = NUM_REGS - 2;
    localparam int CFG_IW = $clog2(NCFG);
    localparam logic [IW-1:0] IDX_CTRL   = IW'(REG_CTRL >> 2);
    localparam logic [IW-1:0] IDX_STATUS = IW'(REG_STATUS >> 2);
    localparam logic [IW-1:0] IDX_CFG0   = IW'(REG_CH_IN >> 2);
    localparam logic [IW-1:0] IDX_NUM    = IW'(NUM_REGS);

    logic                  wr_req;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_strb;
    logic [1:0]            wr_resp;

    eng_state_t            state;
    logic                  done_q, relu_en, irq_en;
    logic [DATA_W-1:0]     cfg_q [NCFG];

    axil_wr_join #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_join (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .wr_ack    (wr_req),
        .wr_resp   (wr_resp)
    );

    logic              busy;
    logic [IW-1:0]     wr_idx;
    logic              wr_map, wr_is_cfg, wr_cfg_en, wr_ctrl, start_req, done_clr, done_set;
    logic [CFG_IW-1:0] wr_cfg_idx;

    assign busy       = (state == RUN);
    assign wr_idx     = wr_addr[ADDR_W-1:2];
    assign wr_map     = (wr_addr[1:0] == 2'b00) && (wr_idx < IDX_NUM);
    assign wr_is_cfg  = wr_map && (wr_idx >= IDX_CFG0);
    assign wr_resp    = (!wr_map || (wr_is_cfg && busy)) ? RESP_SLVERR : RESP_OKAY;
    assign wr_cfg_en  = wr_req && wr_is_cfg && !busy;
    assign wr_cfg_idx = CFG_IW'(wr_idx - IDX_CFG0);
    assign wr_ctrl    = wr_req && wr_map && (wr_idx == IDX_CTRL) && wr_strb[0];
    // A START arriving while RUN (including the eng_done cycle) is acknowledged but dropped.
    assign start_req  = wr_ctrl && wr_data[CTRL_START] && (state == IDLE);
    assign done_clr   = wr_req && wr_map && (wr_idx == IDX_STATUS) && wr_strb[0] && wr_data[STAT_DONE];
    assign done_set   = busy && eng_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            eng_start <= 1'b0;
            done_q    <= 1'b0;
            relu_en   <= 1'b0;
            irq_en    <= 1'b0;
            for (int i = 0; i < NCFG; i++) cfg_q[i] <= '0;
        end else begin
            eng_start <= start_req;
            case (state)
                IDLE:    if (start_req) state <= RUN;
                RUN:     if (eng_done)  state <= IDLE;
                default: state <= IDLE;
            endcase
            if (done_set)
                done_q <= 1'b1;
            else if (start_req || done_clr)
                done_q <= 1'b0;
            if (wr_ctrl) begin
                relu_en <= wr_data[CTRL_RELU_EN];
                irq_en  <= wr_data[CTRL_IRQ_EN];
            end
            if (wr_cfg_en) begin
                for (int b = 0; b < DATA_W/8; b++)
                    if (wr_strb[b]) cfg_q[wr_cfg_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    logic [IW-1:0]     rd_idx;
    logic              rd_map, ar_hs, rvalid_nxt;
    logic [CFG_IW-1:0] rd_cfg_idx;
    logic [DATA_W-1:0] rd_val;

    assign rd_idx     = s_araddr[ADDR_W-1:2];
    assign rd_map     = (s_araddr[1:0] == 2'b00) && (rd_idx < IDX_NUM);
    assign rd_cfg_idx = CFG_IW'(rd_idx - IDX_CFG0);
    assign ar_hs      = s_arvalid && s_arready;
    assign rvalid_nxt = ar_hs ? 1'b1 : ((s_rvalid && s_rready) ? 1'b0 : s_rvalid);

    always_comb begin
        rd_val = '0;
        if (rd_map) begin
            if (rd_idx == IDX_CTRL) begin
                rd_val[CTRL_RELU_EN] = relu_en;
                rd_val[CTRL_IRQ_EN]  = irq_en;
            end else if (rd_idx == IDX_STATUS) begin
                rd_val[STAT_BUSY] = busy;
                rd_val[STAT_DONE] = done_q;
            end else begin
                rd_val = cfg_q[rd_cfg_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
        end else begin
            s_arready <= !rvalid_nxt;
            s_rvalid  <= rvalid_nxt;
            if (ar_hs) begin
                s_rdata <= rd_val;
                s_rresp <= rd_map ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_comb begin
        cfg_flat = '0;
        for (int i = 0; i < NCFG; i++) cfg_flat[i*DATA_W +: DATA_W] = cfg_q[i];
    end

    assign cfg_relu_en = relu_en;
    assign irq         = done_q & irq_en;

endmodule

// File: tb/tb_hbm_fc_bn_res_csr.sv
// Directed bench for the layer CSR block: register map, write/read timing, engine start/done, reset.
module tb_hbm_fc_bn_res_csr;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   s_awaddr = '0;
    logic         s_awvalid = 1'b0;
    logic         s_awready;
    logic [31:0]  s_wdata = '0;
    logic [3:0]   s_wstrb = '0;
    logic         s_wvalid = 1'b0;
    logic         s_wready;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready = 1'b0;
    logic [7:0]   s_araddr = '0;
    logic         s_arvalid = 1'b0;
    logic         s_arready;
    logic [31:0]  s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rvalid;
    logic         s_rready = 1'b0;
    logic [575:0] cfg_flat;
    logic         cfg_relu_en;
    logic         eng_start;
    logic         eng_done = 1'b0;
    logic         irq;

    hbm_fc_bn_res_csr dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .cfg_flat(cfg_flat), .cfg_relu_en(cfg_relu_en),
        .eng_start(eng_start), .eng_done(eng_done), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;

    always @(negedge clk) if (eng_start) start_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout want handshake", nm);
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit hold_b, output logic [1:0] resp);
        bit aw_ok = 0, w_ok = 0, hs_aw, hs_w;
        int n = 0;
        resp = 2'bxx;
        @(negedge clk);
        s_awaddr = a; s_awvalid = 1'b1;
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
        while (!(aw_ok && w_ok)) begin
            if (n >= 50) begin
                tmo("wr_addr_data_hs");
                s_awvalid = 1'b0; s_wvalid = 1'b0;
                return;
            end
            hs_aw = s_awvalid && s_awready;
            hs_w  = s_wvalid && s_wready;
            @(negedge clk);
            n++;
            if (hs_aw) begin aw_ok = 1; s_awvalid = 1'b0; end
            if (hs_w)  begin w_ok = 1;  s_wvalid = 1'b0; end
        end
        n = 0;
        while (!s_bvalid && n < 50) begin @(negedge clk); n++; end
        if (!s_bvalid) begin tmo("wr_bvalid"); return; end
        resp = s_bresp;
        if (!hold_b) begin
            s_bready = 1'b1;
            @(negedge clk);
            s_bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        d = 'x; resp = 2'bxx;
        @(negedge clk);
        s_araddr = a; s_arvalid = 1'b1;
        while (!s_arready && n < 50) begin @(negedge clk); n++; end
        if (!s_arready) begin tmo("rd_ar_hs"); s_arvalid = 1'b0; return; end
        @(negedge clk);
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 50) begin @(negedge clk); n++; end
        if (!s_rvalid) begin tmo("rd_rvalid"); return; end
        d = s_rdata; resp = s_rresp;
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        logic [1:0]  r;
        logic [31:0] d;
        if (v.wr) begin
            axi_write(v.addr, v.data, v.strb, 1'b0, r);
            chk($sformatf("vec%0d_bresp@%02h", k, v.addr), 32'(r), 32'(v.exp_resp));
        end else begin
            axi_read(v.addr, d, r);
            chk($sformatf("vec%0d_rresp@%02h", k, v.addr), 32'(r), 32'(v.exp_resp));
            chk($sformatf("vec%0d_rdata@%02h", k, v.addr), d, v.exp_rdata);
        end
    endtask

    // W leads AW by three cycles; lat counts whole cycles from the AW handshake to bvalid.
    task automatic write_w_first(input logic [7:0] a, input logic [31:0] d,
                                 output logic [1:0] resp, output int lat);
        resp = 2'bxx; lat = -1;
        @(negedge clk);
        chk("wfirst_wready_idle", 32'(s_wready), 32'd1);
        s_wdata = d; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk); s_wvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wfirst_awready_idle", 32'(s_awready), 32'd1);
        s_awaddr = a; s_awvalid = 1'b1;
        @(negedge clk); s_awvalid = 1'b0;
        lat = 0;
        if (s_bvalid) lat = 0;
        else begin
            while (!s_bvalid && lat < 20) begin @(negedge clk); lat++; end
        end
        resp = s_bresp;
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    logic [1:0]  r;
    logic [31:0] d;
    int          lat;
    int          exp_starts;

    initial begin
        exp_starts = 0;
        // Reset values while reset is asserted
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(s_awready), 32'd0);
        chk("rst_wready",  32'(s_wready),  32'd0);
        chk("rst_bvalid",  32'(s_bvalid),  32'd0);
        chk("rst_arready", 32'(s_arready), 32'd0);
        chk("rst_rvalid",  32'(s_rvalid),  32'd0);
        chk("rst_rdata",   s_rdata,        32'd0);
        chk("rst_irq",     32'(irq),       32'd0);
        chk("rst_eng_start", 32'(eng_start), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: every register reads 0 OKAY after reset
        for (int i = 0; i < 19; i++)
            vt.push_back('{1'b0, 8'(i * 4), 32'd0, 4'h0, 2'b00, 32'd0});
        foreach (vt[k]) run_vec(vt[k], k);
        chk("t1_irq", 32'(irq), 32'd0);
        chk("t1_starts", 32'(start_cnt), 32'(exp_starts));

        // 2: W ahead of AW, bvalid one cycle after the AW handshake
        write_w_first(8'h08, 32'd256, r, lat);
        chk("t2_chin_bresp", 32'(r), 32'd0);
        chk("t2_chin_lat", 32'(lat), 32'd1);
        write_w_first(8'h14, 32'd544, r, lat);
        chk("t2_chout_bresp", 32'(r), 32'd0);
        chk("t2_chout_lat", 32'(lat), 32'd1);
        write_w_first(8'h28, 32'h0001_1000, r, lat);
        chk("t2_wtsz_bresp", 32'(r), 32'd0);
        chk("t2_wtsz_lat", 32'(lat), 32'd1);
        chk("t2_cfg_w0", cfg_flat[0*32 +: 32], 32'd256);
        chk("t2_cfg_w3", cfg_flat[3*32 +: 32], 32'd544);
        chk("t2_cfg_w8", cfg_flat[8*32 +: 32], 32'h0001_1000);
        chk("t2_cfg_w17", cfg_flat[17*32 +: 32], 32'd0);
        axi_read(8'h08, d, r); chk("t2_rd_chin", d, 32'd256);
        axi_read(8'h14, d, r); chk("t2_rd_chout", d, 32'd544);
        axi_read(8'h28, d, r); chk("t2_rd_wtsz", d, 32'h0001_1000);

        // 3: start, busy write protection, done and irq
        axi_write(8'h00, 32'h7, 4'hF, 1'b0, r);
        exp_starts++;
        chk("t3_ctrl_bresp", 32'(r), 32'd0);
        chk("t3_starts", 32'(start_cnt), 32'(exp_starts));
        chk("t3_relu", 32'(cfg_relu_en), 32'd1);
        axi_read(8'h04, d, r); chk("t3_status_busy", d, 32'h1);
        axi_read(8'h00, d, r); chk("t3_ctrl_rd", d, 32'h6);
        axi_write(8'h08, 32'd5, 4'hF, 1'b0, r);
        chk("t3_busy_wr_bresp", 32'(r), 32'h2);
        axi_read(8'h08, d, r); chk("t3_chin_kept", d, 32'd256);
        axi_write(8'h00, 32'h7, 4'hF, 1'b0, r);
        chk("t3_busy_start_bresp", 32'(r), 32'd0);
        chk("t3_busy_start_ign", 32'(start_cnt), 32'(exp_starts));
        @(negedge clk); eng_done = 1'b1;
        @(negedge clk); eng_done = 1'b0;
        axi_read(8'h04, d, r); chk("t3_status_done", d, 32'h2);
        chk("t3_irq_set", 32'(irq), 32'd1);
        axi_write(8'h04, 32'h2, 4'hF, 1'b0, r);
        chk("t3_w1c_bresp", 32'(r), 32'd0);
        chk("t3_irq_clr", 32'(irq), 32'd0);
        @(negedge clk); eng_done = 1'b1;
        @(negedge clk); eng_done = 1'b0;
        axi_read(8'h04, d, r); chk("t3_idle_done_ign", d, 32'h0);

        // 4/5: error decode, strobes
        vt.delete();
        vt.push_back('{1'b1, 8'h4C, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'd0});
        vt.push_back('{1'b0, 8'h4D, 32'd0,         4'h0, 2'b10, 32'd0});
        vt.push_back('{1'b0, 8'h4C, 32'd0,         4'h0, 2'b10, 32'd0});
        vt.push_back('{1'b0, 8'h48, 32'd0,         4'h0, 2'b00, 32'd0});
        vt.push_back('{1'b1, 8'h40, 32'h0800_0000, 4'b0100, 2'b00, 32'd0});
        vt.push_back('{1'b0, 8'h40, 32'd0,         4'h0, 2'b00, 32'h0000_0000});
        vt.push_back('{1'b1, 8'h40, 32'h0800_0000, 4'hF, 2'b00, 32'd0});
        vt.push_back('{1'b0, 8'h40, 32'd0,         4'h0, 2'b00, 32'h0800_0000});
        vt.push_back('{1'b1, 8'h42, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'd0});
        vt.push_back('{1'b0, 8'h40, 32'd0,         4'h0, 2'b00, 32'h0800_0000});
        vt.push_back('{1'b1, 8'h3C, 32'h1234_5678, 4'b0011, 2'b00, 32'd0});
        vt.push_back('{1'b0, 8'h3C, 32'd0,         4'h0, 2'b00, 32'h0000_5678});
        foreach (vt[k]) run_vec(vt[k], 100 + k);
        chk("t5_cfg_w14", cfg_flat[14*32 +: 32], 32'h0800_0000);

        // 4: R held stable while rready low
        @(negedge clk);
        s_araddr = 8'h08; s_arvalid = 1'b1;
        @(negedge clk);
        s_araddr = 8'h14;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("t4_hold%0d_rvalid", c), 32'(s_rvalid), 32'd1);
            chk($sformatf("t4_hold%0d_rdata", c), s_rdata, 32'd256);
            chk($sformatf("t4_hold%0d_arready", c), 32'(s_arready), 32'd0);
        end
        s_arvalid = 1'b0; s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        chk("t4_rvalid_drop", 32'(s_rvalid), 32'd0);

        // 6: reset while RUN with a write response pending
        axi_write(8'h00, 32'h5, 4'hF, 1'b0, r);
        exp_starts++;
        chk("t6_starts", 32'(start_cnt), 32'(exp_starts));
        axi_write(8'h08, 32'd9, 4'hF, 1'b1, r);
        chk("t6_pending_bvalid", 32'(s_bvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_bvalid", 32'(s_bvalid), 32'd0);
        chk("t6_async_awready", 32'(s_awready), 32'd0);
        chk("t6_async_irq", 32'(irq), 32'd0);
        chk("t6_async_cfg_w0", cfg_flat[0*32 +: 32], 32'd0);
        chk("t6_async_relu", 32'(cfg_relu_en), 32'd0);
        repeat (2) @(negedge clk);
        s_bready = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        axi_read(8'h04, d, r); chk("t6_status", d, 32'h0);
        axi_read(8'h40, d, r); chk("t6_outbase", d, 32'h0);
        chk("t6_no_spurious_start", 32'(start_cnt), 32'(exp_starts));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
